// File: rtl/cpu_mem_iface_pkg.sv
// ----------------------------------------------------------------------------
// cpu_mem_iface_pkg
// Shared types and helpers for the CPU-to-byte-bus memory interface.
//   ByteW              : width of one memory bus transfer
//   ReqDataSz          : CPU request size code (8/16/32/48-bit)
//   MemIfaceState      : control FSM states of cpu_mem_iface
//   req_size_to_nbytes : number of byte transfers for a request size
// ----------------------------------------------------------------------------
package cpu_mem_iface_pkg;

    localparam int unsigned ByteW = 8;

    typedef enum logic [1:0] {
        ReqSz8  = 2'd0,
        ReqSz16 = 2'd1,
        ReqSz32 = 2'd2,
        ReqSz48 = 2'd3   // instruction fetch, read only
    } ReqDataSz;

    typedef enum logic [1:0] {
        MifIdle  = 2'd0,
        MifIssue = 2'd1,
        MifDone  = 2'd2
    } MemIfaceState;

    function automatic logic [2:0] req_size_to_nbytes(input ReqDataSz sz);
        logic [2:0] n;
        case (sz)
            ReqSz8:  n = 3'd1;
            ReqSz16: n = 3'd2;
            ReqSz32: n = 3'd4;
            ReqSz48: n = 3'd6;
            default: n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/cpu_mem_iface_if.sv
// ----------------------------------------------------------------------------
// cpu_mem_iface_if
// Byte-wide external memory bus with a req/ack handshake.
//   mem_req   : byte transfer request (master -> slave)
//   mem_we    : 1 = write, 0 = read, valid while mem_req = 1
//   mem_addr  : byte address
//   mem_wdata : write byte
//   mem_ack   : transfer completes on an edge with mem_req & mem_ack
//   mem_rdata : read byte, sampled on the ack edge
// Modports: master (the interface unit), slave (the memory).
// ----------------------------------------------------------------------------
interface cpu_mem_iface_if #(
    parameter int unsigned ADDR_WIDTH = 32
) ();
    import cpu_mem_iface_pkg::*;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [ByteW-1:0]      mem_wdata;
    logic                  mem_ack;
    logic [ByteW-1:0]      mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/cpu_mem_iface.sv
// ----------------------------------------------------------------------------
// cpu_mem_iface
// Serialises one CPU read/write request (8/16/32-bit data or 48-bit fetch)
// into little-endian byte transfers on the external memory bus and assembles
// read bytes into the CPU data-in word. The CPU is stalled (cpu_enable_o = 0)
// while a request is pending or in flight.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   cpu_req_rd_i     : read request (level)
//   cpu_req_wr_i     : write request (level)
//   cpu_req_size_i   : ReqDataSz code
//   cpu_addr_i       : start byte address
//   cpu_wdata_i      : write data, low bytes used
//   cpu_enable_o     : 0 stalls the CPU
//   cpu_rdata_o      : last successful read result, zero-extended
//   cpu_done_o       : one-cycle completion pulse
//   cpu_bus_err_o    : error pulse, coincident with cpu_done_o
//   mem_if           : byte bus (master side)
// ----------------------------------------------------------------------------
module cpu_mem_iface
    import cpu_mem_iface_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_MAX_WIDTH = 48,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cpu_req_rd_i,
    input  logic                      cpu_req_wr_i,
    input  logic [1:0]                cpu_req_size_i,
    input  logic [ADDR_WIDTH-1:0]     cpu_addr_i,
    input  logic [31:0]               cpu_wdata_i,
    output logic                      cpu_enable_o,
    output logic [DATA_MAX_WIDTH-1:0] cpu_rdata_o,
    output logic                      cpu_done_o,
    output logic                      cpu_bus_err_o,
    cpu_mem_iface_if.master           mem_if
);

    // Timeout counter counts 0..TIMEOUT_CYCLES-1 ISSUE cycles per byte.
    localparam int unsigned TmoW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    MemIfaceState              state_q, state_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    ReqDataSz                  size_q, size_d;
    logic [31:0]               wdata_q, wdata_d;
    logic                      we_q, we_d;
    logic                      err_q, err_d;
    logic [2:0]                cnt_q, cnt_d;
    logic [TmoW-1:0]           tmo_q, tmo_d;
    logic [DATA_MAX_WIDTH-1:0] asm_q, asm_d;
    logic [DATA_MAX_WIDTH-1:0] rdata_q, rdata_d;

    logic       req_present;
    logic       req_illegal;
    logic [2:0] last_idx;
    logic [5:0] byte_shift;
    logic [31:0] wdata_shifted;

    assign req_present = cpu_req_rd_i | cpu_req_wr_i;
    assign req_illegal = (cpu_req_rd_i & cpu_req_wr_i)
                       | (cpu_req_wr_i & (cpu_req_size_i == 2'd3));
    assign last_idx    = req_size_to_nbytes(size_q) - 3'd1;
    assign byte_shift  = {cnt_q, 3'b000};

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= MifIdle;
            addr_q  <= '0;
            size_q  <= ReqSz8;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            asm_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        asm_d   = asm_q;
        rdata_d = rdata_q;

        unique case (state_q)
            MifIdle: begin
                if (req_present) begin
                    addr_d  = cpu_addr_i;
                    size_d  = ReqDataSz'(cpu_req_size_i);
                    wdata_d = cpu_wdata_i;
                    we_d    = cpu_req_wr_i;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    // Cleared here so unused upper bytes read back as zero.
                    asm_d   = '0;
                    if (req_illegal) begin
                        err_d   = 1'b1;
                        state_d = MifDone;
                    end else begin
                        err_d   = 1'b0;
                        state_d = MifIssue;
                    end
                end
            end

            MifIssue: begin
                // An ack on the timeout cycle still completes the byte.
                if (mem_if.mem_ack) begin
                    if (!we_q) begin
                        asm_d[byte_shift +: 8] = mem_if.mem_rdata;
                    end
                    cnt_d = cnt_q + 3'd1;
                    tmo_d = '0;
                    if (cnt_q == last_idx) begin
                        state_d = MifDone;
                        if (!we_q) begin
                            rdata_d = asm_d;
                        end
                    end
                end else if (TIMEOUT_CYCLES > 0) begin
                    if (tmo_q == TmoLast) begin
                        err_d   = 1'b1;
                        state_d = MifDone;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end

            MifDone: begin
                state_d = MifIdle;
            end

            default: begin
                state_d = MifIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign wdata_shifted = wdata_q >> byte_shift;

    assign cpu_enable_o  = !((state_q == MifIssue) || ((state_q == MifIdle) && req_present));
    assign cpu_rdata_o   = rdata_q;
    assign cpu_done_o    = (state_q == MifDone);
    assign cpu_bus_err_o = (state_q == MifDone) && err_q;

    assign mem_if.mem_req   = (state_q == MifIssue);
    assign mem_if.mem_we    = (state_q == MifIssue) && we_q;
    assign mem_if.mem_addr  = addr_q + ADDR_WIDTH'(cnt_q);
    assign mem_if.mem_wdata = wdata_shifted[7:0];

endmodule
